// File: rtl/out_mem_acc_ctrl_if.sv
// ---------------------------------------------------------------------------
// out_mem_acc_ctrl_if
//   Bundles every non-clock signal of the output-memory sequencer.
//   slave  : controller view (command/psum/drain-consumer inputs, memory
//            port outputs, status outputs)
//   master : environment view (drives commands, psums, out_ready and the
//            memory read data)
//   Groups:
//     command : start, mode, acc_init, drain_base, drain_len, drain_clear
//     psum    : psum_valid/psum_ready, psum_addr, psum_data, psum_last
//     drain   : out_valid/out_ready, out_data
//     status  : busy, done
//     memory  : mem_rd_en/addr/data (port A), mem_wr_en/addr/data (port B)
// ---------------------------------------------------------------------------
interface out_mem_acc_ctrl_if #(
    parameter int NUM_BANK   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                             start;
    logic                             mode;
    logic                             acc_init;
    logic [ADDR_WIDTH-1:0]            drain_base;
    logic [ADDR_WIDTH:0]              drain_len;
    logic                             drain_clear;

    logic                             psum_valid;
    logic                             psum_ready;
    logic [ADDR_WIDTH-1:0]            psum_addr;
    logic [NUM_BANK*DATA_WIDTH-1:0]   psum_data;
    logic                             psum_last;

    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_BANK*DATA_WIDTH-1:0]   out_data;

    logic                             busy;
    logic                             done;

    logic [NUM_BANK-1:0]              mem_rd_en;
    logic [NUM_BANK*ADDR_WIDTH-1:0]   mem_rd_addr;
    logic [NUM_BANK*DATA_WIDTH-1:0]   mem_rd_data;
    logic [NUM_BANK-1:0]              mem_wr_en;
    logic [NUM_BANK*ADDR_WIDTH-1:0]   mem_wr_addr;
    logic [NUM_BANK*DATA_WIDTH-1:0]   mem_wr_data;

    modport slave (
        input  start, mode, acc_init, drain_base, drain_len, drain_clear,
        input  psum_valid, psum_addr, psum_data, psum_last,
        output psum_ready,
        output out_valid, out_data,
        input  out_ready,
        output busy, done,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output start, mode, acc_init, drain_base, drain_len, drain_clear,
        output psum_valid, psum_addr, psum_data, psum_last,
        input  psum_ready,
        input  out_valid, out_data,
        output out_ready,
        input  busy, done,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/out_mem_acc_ctrl.sv
// ---------------------------------------------------------------------------
// out_mem_acc_ctrl
//   Sequencer in front of a banked output memory (port A read, port B write,
//   one-cycle read latency, all banks share one address).
//   ACC   : read-modify-write accumulation of psum vectors, one per cycle,
//           with S2 / W3 forwarding so back-to-back hits on one address sum
//           correctly.
//   DRAIN : streams drain_len vectors from drain_base (wrapping) through a
//           2-entry output FIFO with valid/ready, optionally zeroing each
//           entry on the cycle after it is read.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : out_mem_acc_ctrl_if.slave (command, psum, drain, status,
//                memory port signals)
// ---------------------------------------------------------------------------

// Per-lane "old" operand select and accumulate (wraps modulo 2^DATA_WIDTH).
module out_mem_acc_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  acc_init_i,
    input  logic                  fwd_s2_i,
    input  logic                  fwd_w3_i,
    input  logic [DATA_WIDTH-1:0] psum_i,
    input  logic [DATA_WIDTH-1:0] s2_i,
    input  logic [DATA_WIDTH-1:0] w3_i,
    input  logic [DATA_WIDTH-1:0] mem_i,
    output logic [DATA_WIDTH-1:0] sum_o
);
    logic [DATA_WIDTH-1:0] old;

    always_comb begin
        old = mem_i;
        if (fwd_s2_i)      old = s2_i;
        else if (fwd_w3_i) old = w3_i;
        sum_o = acc_init_i ? psum_i : old + psum_i;
    end
endmodule

module out_mem_acc_ctrl #(
    parameter int NUM_BANK   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    out_mem_acc_ctrl_if.slave     bus
);
    typedef logic [NUM_BANK-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic                  flush_cnt_q;
    logic                  acc_init_q, drain_clear_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   rd_rem_q, out_rem_q;

    // ACC pipeline: vld_pipe_q[1]=S1, [2]=S2 (writes), [3]=W3 (last write copy)
    logic                  acc_fire;
    logic [3:1]            vld_pipe_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q, w3_addr_q;
    vec_t                  s1_psum_q, s2_data_q, w3_data_q;
    vec_t                  psum_vec, rd_vec, sum_vec;
    logic                  fwd_s2, fwd_w3;

    // DRAIN read/FIFO state
    logic                  dr_vld_q;
    logic [ADDR_WIDTH-1:0] dr_addr_q;
    vec_t                  fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [1:0]            occ;
    logic                  push, pop, rd_issue;

    // Memory port muxing
    logic                  rd_en, wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    vec_t                  wr_data;

    assign psum_vec = bus.psum_data;
    assign rd_vec   = bus.mem_rd_data;

    assign acc_fire = (state_q == ACC) && bus.psum_valid;

    assign push = dr_vld_q;
    assign pop  = bus.out_valid && bus.out_ready;
    assign occ  = fifo_cnt_q + {1'b0, dr_vld_q};
    // A pop this cycle frees a slot, which is what allows one read per cycle
    // in steady state while occupancy plus in-flight never exceeds two.
    assign rd_issue = (state_q == DRAIN) && (rd_rem_q != '0) &&
                      ((occ < 2'd2) || pop);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.mode)                state_d = ACC;
                    else if (bus.drain_len != '0) state_d = DRAIN;
                end
            end
            ACC:     if (acc_fire && bus.psum_last) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q) state_d = IDLE;
            DRAIN:   if (pop && (out_rem_q == (ADDR_WIDTH+1)'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An empty drain never leaves IDLE but still reports completion.
        done_d = ((state_q != IDLE) && (state_d == IDLE)) ||
                 ((state_q == IDLE) && bus.start && bus.mode && (bus.drain_len == '0));
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (acc_fire) begin
            rd_en   = 1'b1;
            rd_addr = bus.psum_addr;
        end else if (rd_issue) begin
            rd_en   = 1'b1;
            rd_addr = rd_addr_q;
        end
        if (vld_pipe_q[2]) begin
            wr_en   = 1'b1;
            wr_addr = s2_addr_q;
            wr_data = s2_data_q;
        end else if (dr_vld_q && drain_clear_q) begin
            wr_en   = 1'b1;
            wr_addr = dr_addr_q;
        end
    end

    assign bus.psum_ready  = (state_q == ACC);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.out_valid   = (fifo_cnt_q != 2'd0);
    assign bus.out_data    = fifo_q[rd_ptr_q];
    assign bus.mem_rd_en   = {NUM_BANK{rd_en}};
    assign bus.mem_rd_addr = {NUM_BANK{rd_addr}};
    assign bus.mem_wr_en   = {NUM_BANK{wr_en}};
    assign bus.mem_wr_addr = {NUM_BANK{wr_addr}};
    assign bus.mem_wr_data = wr_data;

    // ---------------- ACC datapath ----------------
    // S2 holds the newest value for its address; W3 covers the entry written
    // in the same cycle S1's read was issued (memory returned stale data).
    assign fwd_s2 = vld_pipe_q[2] && (s2_addr_q == s1_addr_q);
    assign fwd_w3 = vld_pipe_q[3] && (w3_addr_q == s1_addr_q);

    out_mem_acc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [NUM_BANK-1:0] (
        .acc_init_i (acc_init_q),
        .fwd_s2_i   (fwd_s2),
        .fwd_w3_i   (fwd_w3),
        .psum_i     (s1_psum_q),
        .s2_i       (s2_data_q),
        .w3_i       (w3_data_q),
        .mem_i      (rd_vec),
        .sum_o      (sum_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            w3_addr_q  <= '0;
            s1_psum_q  <= '0;
            s2_data_q  <= '0;
            w3_data_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[2:1], acc_fire};
            if (acc_fire) begin
                s1_addr_q <= bus.psum_addr;
                s1_psum_q <= psum_vec;
            end
            if (vld_pipe_q[1]) begin
                s2_addr_q <= s1_addr_q;
                s2_data_q <= sum_vec;
            end
            if (vld_pipe_q[2]) begin
                w3_addr_q <= s2_addr_q;
                w3_data_q <= s2_data_q;
            end
        end
    end

    // ---------------- pass control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q   <= 1'b0;
            acc_init_q    <= 1'b0;
            drain_clear_q <= 1'b0;
            rd_addr_q     <= '0;
            rd_rem_q      <= '0;
            out_rem_q     <= '0;
        end else begin
            flush_cnt_q <= (state_q == FLUSH) ? ~flush_cnt_q : 1'b0;
            if ((state_q == IDLE) && bus.start) begin
                acc_init_q    <= bus.acc_init;
                drain_clear_q <= bus.drain_clear;
                rd_addr_q     <= bus.drain_base;
                rd_rem_q      <= bus.drain_len;
                out_rem_q     <= bus.drain_len;
            end else begin
                if (rd_issue) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    rd_rem_q  <= rd_rem_q - 1'b1;
                end
                if (pop) out_rem_q <= out_rem_q - 1'b1;
            end
        end
    end

    // ---------------- DRAIN read tracking and output FIFO ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_vld_q   <= 1'b0;
            dr_addr_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            dr_vld_q <= rd_issue;
            if (rd_issue) dr_addr_q <= rd_addr_q;
            if (push) begin
                fifo_q[wr_ptr_q] <= rd_vec;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_out_mem_acc_ctrl.sv
module tb_out_mem_acc_ctrl;
    localparam int NB    = 16;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    typedef logic [NB-1:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    out_mem_acc_ctrl_if #(.NUM_BANK(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    out_mem_acc_ctrl #(.NUM_BANK(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int   ready_mode = 0;
    vec_t exp_q [$];
    vec_t ref_mem [DEPTH];
    logic [AW-1:0] pa_addr [$];
    vec_t          pa_data [$];
    int            pa_gap  [$];

    // ---------------- banked memory environment ----------------
    vec_t rd_q;
    assign bus.mem_rd_data = rd_q;
    initial begin
        logic [DW-1:0] mem [NB][DEPTH];
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) mem[b][a] = '0;
        rd_q = '0;
        forever begin
            @(posedge clk);
            for (int b = 0; b < NB; b++) begin
                if (bus.mem_rd_en[b]) rd_q[b] <= mem[b][bus.mem_rd_addr[b*AW +: AW]];
                if (bus.mem_wr_en[b]) mem[b][bus.mem_wr_addr[b*AW +: AW]] <= bus.mem_wr_data[b*DW +: DW];
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       begin bus.out_ready = (ph % 3 == 0); ph++; end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic vchk(input string name, input vec_t act, input vec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_stall;
        vec_t prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.done)         done_cnt++;
                if (bus.mem_wr_en[0]) wr_cnt++;
                if (bus.mem_rd_en[0]) rd_cnt++;
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'(1));
                    vchk("stall_hold", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL drain_extra: got %h expected no vector", bus.out_data);
                    end else begin
                        vchk("drain_data", bus.out_data, exp_q.pop_front());
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic vec_t fill(input logic [DW-1:0] v);
        vec_t r;
        for (int l = 0; l < NB; l++) r[l] = v;
        return r;
    endfunction

    function automatic vec_t lane_idx(input int mul);
        vec_t r;
        for (int l = 0; l < NB; l++) r[l] = DW'(l * mul);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int l = 0; l < NB; l++) r[l] = $urandom;
        return r;
    endfunction

    task automatic push_psum(input logic [AW-1:0] a, input vec_t d, input int gap);
        pa_addr.push_back(a); pa_data.push_back(d); pa_gap.push_back(gap);
    endtask

    task automatic pulse_start(input logic m, input logic init, input logic [AW-1:0] base,
                               input logic [AW:0] len, input logic clr);
        bus.start = 1'b1; bus.mode = m; bus.acc_init = init;
        bus.drain_base = base; bus.drain_len = len; bus.drain_clear = clr;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k;
        k = 0;
        while (!bus.done && k < 3000) begin tick(); k++; end
        chk({name, "_seen"}, 64'(bus.done), 64'(1));
        tick(); tick();
        chk({name, "_once"}, 64'(done_cnt - d0), 64'(1));
        chk({name, "_idle"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic run_acc(input logic init);
        int n, d0;
        n  = pa_addr.size();
        d0 = done_cnt;
        pulse_start(1'b0, init, '0, '0, 1'b0);
        for (int k = 0; k < n; k++) begin
            bus.psum_valid = 1'b0;
            repeat (pa_gap[k]) tick();
            bus.psum_valid = 1'b1;
            bus.psum_addr  = pa_addr[k];
            bus.psum_data  = pa_data[k];
            bus.psum_last  = (k == n - 1);
            chk("acc_ready", 64'(bus.psum_ready), 64'(1));
            tick();
            for (int l = 0; l < NB; l++)
                ref_mem[pa_addr[k]][l] = init ? pa_data[k][l] : ref_mem[pa_addr[k]][l] + pa_data[k][l];
        end
        bus.psum_valid = 1'b0;
        bus.psum_last  = 1'b0;
        pa_addr.delete(); pa_data.delete(); pa_gap.delete();
        wait_done("acc_done", d0);
    endtask

    task automatic run_drain(input logic [AW-1:0] base, input int len, input logic clr);
        logic [AW-1:0] a;
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < len; k++) begin
            a = base + AW'(k);
            exp_q.push_back(ref_mem[a]);
            if (clr) ref_mem[a] = '0;
        end
        pulse_start(1'b1, 1'b0, base, (AW+1)'(len), clr);
        wait_done("drain_done", d0);
        chk("drain_drained", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, w0, r0;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.acc_init = 1'b0;
        bus.drain_base = '0; bus.drain_len = '0; bus.drain_clear = 1'b0;
        bus.psum_valid = 1'b0; bus.psum_addr = '0; bus.psum_data = '0; bus.psum_last = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(bus.busy),       64'(0));
        chk("rst_done",   64'(bus.done),       64'(0));
        chk("rst_ready",  64'(bus.psum_ready), 64'(0));
        chk("rst_ovalid", 64'(bus.out_valid),  64'(0));
        chk("rst_rden",   64'(bus.mem_rd_en),  64'(0));
        chk("rst_wren",   64'(bus.mem_wr_en),  64'(0));
        vchk("rst_odata", bus.out_data, '0);
        rst = 1'b0;
        tick();

        // basic init + accumulate, lane i = i then 2i
        for (int k = 0; k < 4; k++) push_psum(AW'(k), lane_idx(1), 0);
        run_acc(1'b1);
        for (int k = 0; k < 4; k++) push_psum(AW'(k), lane_idx(1), 0);
        run_acc(1'b0);
        vchk("basic_ref", ref_mem[2], lane_idx(2));
        run_drain(8'd0, 4, 1'b0);

        // back-to-back same-address hazard (S2 path)
        w0 = wr_cnt;
        for (int k = 1; k <= 5; k++) push_psum(8'd7, fill(DW'(k)), 0);
        run_acc(1'b0);
        chk("hazard_writes", 64'(wr_cnt - w0), 64'(5));

        // one-cycle gap (W3 path)
        push_psum(8'd9, fill(32'd10), 0);
        push_psum(8'd9, fill(32'd20), 1);
        run_acc(1'b0);

        // overflow wrap
        push_psum(8'd20, fill(32'hFFFF_FFFF), 0);
        run_acc(1'b1);
        push_psum(8'd20, fill(32'd2), 0);
        run_acc(1'b0);
        vchk("ovf_ref", ref_mem[20], fill(32'd1));
        run_drain(8'd7, 14, 1'b0);

        // wrapping drain with stalls and clear
        push_psum(8'd254, rand_vec(), 0);
        push_psum(8'd255, rand_vec(), 0);
        push_psum(8'd0,   rand_vec(), 0);
        push_psum(8'd1,   rand_vec(), 0);
        run_acc(1'b1);
        ready_mode = 1;
        run_drain(8'd254, 4, 1'b1);
        ready_mode = 0;
        run_drain(8'd254, 4, 1'b0);

        // empty drain
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        pulse_start(1'b1, 1'b0, 8'd50, '0, 1'b1);
        chk("len0_done", 64'(bus.done), 64'(1));
        tick(); tick();
        chk("len0_once",  64'(done_cnt - d0), 64'(1));
        chk("len0_noread", 64'(rd_cnt - r0), 64'(0));
        chk("len0_nowrite", 64'(wr_cnt - w0), 64'(0));

        // start while busy is ignored: a drain start mid-ACC must not change mode
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1, '0, '0, 1'b0);
        bus.start = 1'b1; bus.mode = 1'b1; bus.drain_len = 9'd3;
        tick();
        bus.start = 1'b0;
        chk("busy_ready", 64'(bus.psum_ready), 64'(1));
        bus.psum_valid = 1'b1; bus.psum_addr = 8'd60; bus.psum_data = fill(32'd5); bus.psum_last = 1'b1;
        tick();
        ref_mem[60] = fill(32'd5);
        bus.psum_valid = 1'b0; bus.psum_last = 1'b0;
        wait_done("busy_start", d0);

        // randomized passes
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) push_psum(AW'(32 + k), rand_vec(), 0);
            run_acc(1'b1);
            for (int k = 0; k < 20; k++)
                push_psum(AW'(32 + $urandom_range(0, 3)), rand_vec(), $urandom_range(0, 2));
            run_acc(1'b0);
            ready_mode = 2;
            run_drain(8'd32, 16, 1'($urandom_range(0, 1)));
            ready_mode = 0;
        end
        run_drain(8'd60, 1, 1'b0);

        // reset during ACC at the third vector
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1, '0, '0, 1'b0);
        bus.psum_valid = 1'b1;
        bus.psum_addr = 8'd200; bus.psum_data = rand_vec(); tick();
        bus.psum_addr = 8'd201; bus.psum_data = rand_vec(); tick();
        bus.psum_addr = 8'd202; bus.psum_data = rand_vec();
        #2 rst = 1'b1;
        tick();
        chk("mrst_busy",  64'(bus.busy),       64'(0));
        chk("mrst_done",  64'(bus.done),       64'(0));
        chk("mrst_ready", 64'(bus.psum_ready), 64'(0));
        chk("mrst_rden",  64'(bus.mem_rd_en),  64'(0));
        chk("mrst_wren",  64'(bus.mem_wr_en),  64'(0));
        chk("mrst_ovalid", 64'(bus.out_valid), 64'(0));
        bus.psum_valid = 1'b0;
        rst = 1'b0;
        repeat (4) tick();
        chk("mrst_no_done", 64'(done_cnt - d0), 64'(0));
        push_psum(8'd200, rand_vec(), 0);
        push_psum(8'd201, rand_vec(), 0);
        run_acc(1'b1);
        run_drain(8'd200, 2, 1'b0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
